// File: rtl/mem_rr_arbiter_if.sv
// Bus bundle between the requesting masters and the SRAM round-robin arbiter.
// The masters drive requests and lock; the arbiter drives grant, chip select and ready.
interface mem_rr_arbiter_if #(
  parameter int N_REQ = 4
);
  logic             skip_wait;
  logic [N_REQ-1:0] read_request;
  logic [N_REQ-1:0] write_request;
  logic [N_REQ-1:0] lock;
  logic [N_REQ-1:0] grant;
  logic [1:0]       grant_id;
  logic             memsel;
  logic             rwbar;
  logic             ready;

  modport master (
    output skip_wait, read_request, write_request, lock,
    input  grant, grant_id, memsel, rwbar, ready
  );

  modport slave (
    input  skip_wait, read_request, write_request, lock,
    output grant, grant_id, memsel, rwbar, ready
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter and access sequencer for the shared SRAM port.
// One requester is granted per transfer: IDLE -> ACCESS (wait states) -> DONE (ready pulse).
module mem_rr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_rr_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       last;
  logic [1:0]       winner;
  logic             lock_valid;
  logic [1:0]       lock_owner;
  logic [3:0]       count;

  logic [N_REQ-1:0] req_any;
  logic [1:0]       pick;
  logic [1:0]       cand;
  logic             pick_found;

  // A locked owner that is still requesting wins outright; otherwise scan
  // forward from the requester after the last winner, wrapping at N_REQ.
  always_comb begin
    req_any    = bus.read_request | bus.write_request;
    pick       = last;
    cand       = '0;
    pick_found = 1'b0;
    if (lock_valid && req_any[lock_owner]) begin
      pick       = lock_owner;
      pick_found = 1'b1;
    end else begin
      for (int i = 1; i <= N_REQ; i++) begin
        cand = 2'((int'(last) + i) % N_REQ);
        if (!pick_found && req_any[cand]) begin
          pick       = cand;
          pick_found = 1'b1;
        end
      end
    end
  end

  // All outputs are registered; ready is raised only on entry to DONE so it
  // can never last longer than the single DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      last         <= 2'(N_REQ - 1);
      winner       <= '0;
      lock_valid   <= 1'b0;
      lock_owner   <= '0;
      count        <= '0;
      bus.grant    <= '0;
      bus.grant_id <= '0;
      bus.memsel   <= 1'b0;
      bus.rwbar    <= 1'b1;
      bus.ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.ready <= 1'b0;
          if (lock_valid && !req_any[lock_owner]) begin
            lock_valid <= 1'b0;
          end
          if (|req_any) begin
            state        <= ACCESS;
            winner       <= pick;
            bus.grant    <= N_REQ'(1) << pick;
            bus.grant_id <= pick;
            bus.memsel   <= 1'b1;
            bus.rwbar    <= ~bus.write_request[pick];
            count        <= bus.skip_wait ? 4'd0 : 4'(WAIT_STATES);
          end
        end

        ACCESS: begin
          if (count == 4'd0) begin
            state     <= DONE;
            bus.ready <= 1'b1;
          end else begin
            count <= count - 4'd1;
          end
        end

        DONE: begin
          state        <= IDLE;
          bus.ready    <= 1'b0;
          bus.grant    <= '0;
          bus.grant_id <= '0;
          bus.memsel   <= 1'b0;
          bus.rwbar    <= 1'b1;
          last         <= winner;
          lock_valid   <= bus.lock[winner];
          lock_owner   <= winner;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: table-driven single transfers with a
// scoreboard queue, plus hand-written round-robin, lock and mid-access reset sequences.
module tb_mem_rr_arbiter;

  logic clk;
  logic rst;

  mem_rr_arbiter_if #(.N_REQ(4)) bus ();

  mem_rr_arbiter #(.N_REQ(4), .WAIT_STATES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rd;
    logic [3:0] wr;
    logic       skip;
    logic [3:0] exp_grant;
    logic [1:0] exp_id;
    logic       exp_rwbar;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] id;
    logic       rwbar;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One full transfer from IDLE: drive, wait for grant, measure ready latency, release.
  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    int   waited;
    int   lat;
    bus.read_request  = v.rd;
    bus.write_request = v.wr;
    bus.skip_wait     = v.skip;
    e.grant = v.exp_grant; e.id = v.exp_id; e.rwbar = v.exp_rwbar; e.lat = v.exp_lat;
    sb.push_back(e);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.grant == 4'b0 && waited < 20);
    if (bus.grant == 4'b0) begin
      checkOutput({tag, "_grant_timeout"}, 0, 1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_grant"}, int'(bus.grant), int'(e.grant));
      checkOutput({tag, "_grant_id"}, int'(bus.grant_id), int'(e.id));
      checkOutput({tag, "_memsel"}, int'(bus.memsel), 1);
      lat = 0;
      while (!bus.ready && lat < 20) begin
        checkOutput({tag, "_rwbar"}, int'(bus.rwbar), int'(e.rwbar));
        @(negedge clk);
        lat++;
      end
      checkOutput({tag, "_latency"}, lat, e.lat);
      checkOutput({tag, "_rwbar_done"}, int'(bus.rwbar), int'(e.rwbar));
      checkOutput({tag, "_grant_done"}, int'(bus.grant), int'(e.grant));
    end
    bus.read_request  = '0;
    bus.write_request = '0;
    bus.skip_wait     = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_ready_fall"}, int'(bus.ready), 0);
    checkOutput({tag, "_grant_fall"}, int'(bus.grant), 0);
    checkOutput({tag, "_memsel_fall"}, int'(bus.memsel), 0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_grant"}, int'(bus.grant), 0);
    checkOutput({tag, "_grant_id"}, int'(bus.grant_id), 0);
    checkOutput({tag, "_memsel"}, int'(bus.memsel), 0);
    checkOutput({tag, "_rwbar"}, int'(bus.rwbar), 1);
    checkOutput({tag, "_ready"}, int'(bus.ready), 0);
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  // Watch grant rising edges against an expected id sequence, checking
  // period, one ready per grant, and one-hot grant.
  task automatic runSequence(input logic [1:0] ids[$], input string tag, input bit lock_test);
    logic [3:0] prev_grant = '0;
    logic       prev_ready = 1'b0;
    int         grants = 0, readies = 0, last_rise = 0, cyc = 0, beats1 = 0;
    int         total = ids.size();
    exp_t       e;
    foreach (ids[k]) begin
      e.grant = 4'b1 << ids[k]; e.id = ids[k]; e.rwbar = 1'b1; e.lat = 3;
      sb.push_back(e);
    end
    while (cyc < 200 && !(grants == total && readies == 1)) begin
      @(negedge clk);
      cyc++;
      if (bus.grant != 4'b0 && prev_grant == 4'b0) begin
        if (grants > 0) begin
          checkOutput({tag, "_ready_per_grant"}, readies, 1);
          checkOutput({tag, "_period"}, cyc - last_rise, 5);
        end
        e = sb.pop_front();
        checkOutput({tag, "_grant_id"}, int'(bus.grant_id), int'(e.id));
        checkOutput({tag, "_grant"}, int'(bus.grant), int'(e.grant));
        if (lock_test && bus.grant_id == 2'd1) begin
          beats1++;
          if (beats1 == 4) bus.lock = 4'b0000;
        end
        readies   = 0;
        last_rise = cyc;
        grants++;
      end
      if ((bus.grant & (bus.grant - 4'b1)) != 4'b0)
        checkOutput({tag, "_onehot"}, int'(bus.grant), 0);
      if (bus.ready) begin
        readies++;
        if (prev_ready) checkOutput({tag, "_ready_double"}, 1, 0);
      end
      prev_grant = bus.grant;
      prev_ready = bus.ready;
    end
    if (grants != total || readies != 1) checkOutput({tag, "_timeout"}, grants, total);
    while (sb.size() > 0) void'(sb.pop_front());
    bus.read_request = '0;
    bus.lock         = '0;
    @(negedge clk);
    @(negedge clk);
    checkIdle({tag, "_end"});
  endtask

  initial begin
    logic [1:0] rr_ids[$];
    logic [1:0] lock_ids[$];
    int         waited;

    bus.read_request  = '0;
    bus.write_request = '0;
    bus.lock          = '0;
    bus.skip_wait     = 1'b0;

    vecs[0] = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 3};
    vecs[1] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1};
    vecs[2] = '{4'b0000, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 3};
    vecs[3] = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 3};
    vecs[4] = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 3};
    vecs[5] = '{4'b0000, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 1};
    vecs[6] = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 3};
    vecs[7] = '{4'b0110, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 3};

    doReset(3);
    checkIdle("reset");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkIdle("idle_hold");
    end

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    doReset(2);
    rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.read_request = 4'b1111;
    runSequence(rr_ids, "rr", 1'b0);

    lock_ids = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    bus.lock         = 4'b0010;
    bus.read_request = 4'b0110;
    runSequence(lock_ids, "lock", 1'b1);

    bus.read_request = 4'b0100;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.grant == 4'b0 && waited < 20);
    checkOutput("midrst_grant", int'(bus.grant), 4'b0100);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkIdle("midrst_now");
    @(negedge clk);
    checkIdle("midrst_hold");
    bus.read_request = '0;
    rst = 1'b1;
    applyStimulus('{4'b0110, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 3}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter and access sequencer for the shared SRAM port. It sits between up to four bus masters (instruction cache, data cache, DMA, debug) and the `memory` block. It grants one requester at a time and drives `memsel`/`rwbar` for a programmable number of wait states. It returns a one-cycle `ready` pulse per transfer. A per-requester lock input lets a cache hold the bus across back-to-back beats of a line fill or write-back.

## Interface
- `N_REQ`, 4: number of requesters; grant vectors are `N_REQ` wide.
- `WAIT_STATES`, 2: extra cycles `memsel` is held before `ready`; legal range 0..15.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `skip_wait`  in  1  when 1, the current access uses 0 wait states; sampled on entry to ACCESS.
- `read_request`  in  N_REQ  per-requester read request, level, held until `ready`.
- `write_request`  in  N_REQ  per-requester write request, level, held until `ready`.
- `lock`  in  N_REQ  requester asks to keep the bus for its next transfer; sampled in DONE.
- `grant`  out  N_REQ  one-hot grant; all zero when idle.
- `grant_id`  out  2  binary index of the granted requester; 0 when idle.
- `memsel`  out  1  SRAM chip select.
- `rwbar`  out  1  1 = read, 0 = write; valid while `memsel`=1.
- `ready`  out  1  one-cycle completion pulse to the granted requester.

## Operation
- States:
  - IDLE: all outputs are at reset values; arbitration happens here.
  - ACCESS: `grant`, `memsel` and `rwbar` are driven; the wait counter runs.
  - DONE: `ready`=1; `grant`, `memsel` and `rwbar` are still held.
- IDLE -> ACCESS when any bit of `read_request | write_request` is set. The winner is registered on that edge.
- Winner selection:
  - If `lock_owner_valid` is set and the owner is requesting, the owner wins.
  - Otherwise the first requesting index in the order `last+1, last+2, ...` wins, modulo N_REQ.
- `rwbar` is registered as `~write_request[winner]`. If read and write are both set for one requester, the write wins.
- ACCESS loads the counter with `skip_wait ? 0 : WAIT_STATES`, decrements it each cycle, and moves to DONE on the cycle the counter is 0. ACCESS therefore lasts `count+1` cycles.
- DONE -> IDLE unconditionally after 1 cycle.
  - On that edge `last` is set to the winner.
  - `lock_owner_valid` is set to `lock[winner]`, with the owner recorded. Otherwise it is cleared.
- The forced IDLE cycle between transfers is the bus turnaround. Requesters drop their request on the edge after `ready`, so IDLE never samples a stale request.
- Lock release: the owner lowers `lock` on its last beat. If the owner has no request in IDLE, the lock is cleared and normal round-robin applies.
- A request withdrawn during ACCESS is not aborted: the access runs to DONE and `ready` still pulses.
- Requests from non-granted masters are ignored until IDLE; there is no pre-emption.

## Timing
- Reset values: `grant`=0, `grant_id`=0, `memsel`=0, `rwbar`=1, `ready`=0, state=IDLE, `last`=N_REQ-1 (requester 0 has first priority), lock cleared.
- Reset asserted in any state forces reset values on the next edge. An in-flight access is dropped and no `ready` is issued.
- Request seen in IDLE at edge E0: `grant`/`memsel` rise at E0. `ready` rises at E0+WAIT_STATES+1 and falls one cycle later, together with `grant`/`memsel`.
  - Default parameters: the request-to-`ready` latency is 3 cycles after the grant edge.
  - With `skip_wait`: `ready` is 1 cycle after grant.
- Transfer period is WAIT_STATES+3 cycles: IDLE, ACCESS×(W+1), DONE. With defaults that is 5 cycles; with `skip_wait` it is 3.
- `ready` is never high for more than 1 consecutive cycle. `grant` is never multi-hot.

## Test plan
- Reset and idle: `rst`=0 for 3 cycles, then 1 with no requests -> `grant`=0, `memsel`=0, `rwbar`=1 and `ready`=0 hold for 20 cycles.
- Single read from requester 1 (`read_request`=4'b0010), defaults:
  - `grant`=4'b0010, `memsel`=1, `rwbar`=1 from the grant edge.
  - `ready` pulses exactly at grant+3.
  - Repeat with `skip_wait`=1 -> `ready` at grant+1.
- Write: `write_request`=4'b0010 -> `rwbar`=0 for the whole access. With read and write both set on requester 1 -> `rwbar`=0.
- Round-robin: all four requesters hold requests continuously after reset -> grants come in the order 0,1,2,3,0. Each transfer is 5 cycles and exactly one `ready` pulse occurs per grant.
- Lock: requester 1 raises `lock` for 4 beats while requester 2 also requests -> 4 consecutive grants to 1, then the next grant goes to 2.
- Reset mid-access: `rst`=0 during ACCESS -> all outputs are at reset values on the next edge and no `ready` appears. The first grant after reset goes to the lowest requesting index.
